// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encodings,
// the default hold limit and the hold-counter width helper.
package mux2_arbiter_pkg;

    localparam int MAX_HOLD_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    // Counter only needs to reach MAX_HOLD-1; a legal MAX_HOLD of 2 still needs one bit.
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold <= 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/mux2_arbiter_sel.sv
// Plain 2:1 data select shared by both requesters; s=0 routes i[0], s=1 routes i[1].
module mux2_sel (
    input  logic [1:0] i,
    input  logic       s,
    output logic       o
);

    assign o = s ? i[1] : i[0];

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter owning a shared 2:1 mux. Ties alternate on a
// last-served pointer and a hold counter caps how long one side can starve the other.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] i,
    output logic [1:0] gnt,
    output logic       s,
    output logic       o,
    output logic       valid
);

    localparam int                CNT_W     = hold_cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    arb_state_t       nxt_state;
    logic [CNT_W-1:0] hold_cnt;
    logic             last_served;
    logic             sel_out;

    // Next-state decision. A forced switch only happens when the other side
    // is actually waiting, so an uncontended grant holds indefinitely.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                case (req)
                    2'b01:   nxt_state = G0;
                    2'b10:   nxt_state = G1;
                    2'b11:   nxt_state = last_served ? G0 : G1;
                    default: nxt_state = IDLE;
                endcase
            end
            G0: begin
                if (!req[0]) begin
                    nxt_state = req[1] ? G1 : IDLE;
                end else if (req[1] && (hold_cnt == HOLD_LAST)) begin
                    nxt_state = G1;
                end
            end
            G1: begin
                if (!req[1]) begin
                    nxt_state = req[0] ? G0 : IDLE;
                end else if (req[0] && (hold_cnt == HOLD_LAST)) begin
                    nxt_state = G0;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State, hold counter, pointer and the registered output decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
            gnt         <= 2'b00;
            s           <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state <= nxt_state;
            gnt   <= {nxt_state == G1, nxt_state == G0};
            s     <= (nxt_state == G1);
            valid <= (nxt_state != IDLE);

            if (nxt_state != state) begin
                hold_cnt <= '0;
                if (nxt_state == G0) begin
                    last_served <= 1'b0;
                end else if (nxt_state == G1) begin
                    last_served <= 1'b1;
                end
            end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    mux2_sel u_sel (
        .i (i),
        .s (s),
        .o (sel_out)
    );

    // Gate with valid so o reads 0 whenever nobody owns the mux, including in reset.
    assign o = valid & sel_out;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and random check of mux2_arbiter against a run-length reference
// model; expected {gnt,s,valid,o} values flow through a scoreboard queue.
module tb_mux2_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] i;
    logic [1:0] gnt;
    logic       s;
    logic       o;
    logic       valid;

    logic [4:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    // Reference model: owner 0=none, 1=requester 0, 2=requester 1.
    int m_owner;
    int m_run;
    int m_last;

    mux2_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i     (i),
        .gnt   (gnt),
        .s     (s),
        .o     (o),
        .valid (valid)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Model: m_run counts cycles already spent in the current grant.
    task automatic model_reset();
        m_owner = 0;
        m_run   = 0;
        m_last  = 1;
    endtask

    task automatic model_edge(input logic [1:0] r);
        int nxt;
        int k;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (r == 2'b01)      nxt = 1;
            else if (r == 2'b10) nxt = 2;
            else if (r == 2'b11) nxt = (m_last == 1) ? 1 : 2;
        end else begin
            k = m_owner - 1;
            if (!r[k])                             nxt = r[1-k] ? (2 - k) : 0;
            else if (r[1-k] && m_run >= MAX_HOLD) nxt = 2 - k;
        end
        if (nxt != m_owner) begin
            m_run = (nxt != 0) ? 1 : 0;
            if (nxt != 0) m_last = nxt - 1;
        end else if (nxt != 0) begin
            m_run = m_run + 1;
        end
        m_owner = nxt;
    endtask

    function automatic logic [4:0] model_out(input logic [1:0] iv);
        logic [1:0] g;
        logic       sv;
        logic       v;
        logic       ov;
        g  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        sv = (m_owner == 2);
        v  = (m_owner != 0);
        ov = v ? iv[sv] : 1'b0;
        return {g, sv, v, ov};
    endfunction

    // Scoreboard compare of one observation against the oldest expectation.
    task automatic compare(input string tag);
        logic [4:0] got;
        logic [4:0] exp;
        got   = {gnt, s, valid, o};
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $error("FAIL %s: scoreboard empty, observed gnt/s/valid/o=%b", tag, got);
        end else begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
                n_bad = n_bad + 1;
                $error("FAIL %s: observed gnt/s/valid/o=%b expected %b", tag, got, exp);
            end
        end
    endtask

    // Driver: apply inputs away from the edge, predict, then sample after the edge.
    task automatic cycle(input logic [1:0] r, input logic [1:0] iv, input string tag);
        @(negedge clk);
        req = r;
        i   = iv;
        model_edge(r);
        exp_q.push_back(model_out(iv));
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Async reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(5'b00000);
        compare(tag);
        @(negedge clk);
        req = 2'b11;
        i   = 2'b11;
        @(posedge clk);
        #1;
        exp_q.push_back(5'b00000);
        compare({tag, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b00;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        req   = 2'b00;
        i     = 2'b00;
        model_reset();

        #2;
        rst_n = 1'b0;
        #2;
        exp_q.push_back(5'b00000);
        compare("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: one-cycle latency, o follows i[0].
        cycle(2'b01, 2'b10, "r026_g0_o0");
        cycle(2'b01, 2'b11, "r026_g0_o1");
        cycle(2'b01, 2'b01, "r026_g0_hold");
        cycle(2'b00, 2'b11, "idle_return");
        cycle(2'b10, 2'b01, "single_g1_o0");
        cycle(2'b10, 2'b10, "single_g1_o1");
        cycle(2'b00, 2'b00, "idle_again");

        // First tie after reset goes to requester 0, then direct handoff.
        do_reset("rst_before_tie");
        cycle(2'b11, 2'b01, "r027_tie_g0");
        cycle(2'b10, 2'b10, "r027_handoff_g1");
        cycle(2'b10, 2'b00, "r027_g1_o0");
        cycle(2'b00, 2'b11, "r027_idle");

        // Sustained contention alternates every MAX_HOLD cycles.
        repeat (4 * MAX_HOLD + 2) cycle(2'b11, 2'($urandom_range(0, 3)), "r028_alternate");
        cycle(2'b00, 2'b00, "r028_idle");

        // Uncontended hold saturates; late request switches at the next edge.
        repeat (20) cycle(2'b01, 2'($urandom_range(0, 3)), "r029_hold");
        cycle(2'b11, 2'b10, "r029_late_switch");
        cycle(2'b10, 2'b10, "r029_g1");

        // Reset in the middle of a G1 grant, then pointer restarts at 1.
        do_reset("r030_async");
        cycle(2'b11, 2'b01, "r030_tie_g0");
        cycle(2'b11, 2'b00, "r030_g0_cont");

        // Random traffic against the model.
        repeat (80) cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "random");

        n_cmp = n_cmp + 1;
        assert (exp_q.size() == 0) else begin
            n_bad = n_bad + 1;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive cycles one requester keeps the grant while the other requester waits; legal range 2..255.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  2  req[k] high = requester k wants the shared mux.
REQ-005 Port: i  input  2  data bits; i[k] belongs to requester k.
REQ-006 Port: gnt  output  2  one-hot or zero; gnt[k] high = requester k owns the mux.
REQ-007 Port: s  output  1  mux select; 0 routes i[0], 1 routes i[1].
REQ-008 Port: o  output  1  shared mux output.
REQ-009 Port: valid  output  1  high when o carries a granted requester's data (equals |gnt).

Function
REQ-010 FSM states: IDLE, G0 (requester 0 granted), G1 (requester 1 granted); gnt, s and valid are registered decodes of state.
REQ-011 o: combinational; i[s] when valid is high, 0 otherwise.
REQ-012 IDLE, exactly one req bit high at edge N -> matching Gk from cycle N+1 (one-cycle grant latency).
REQ-013 IDLE, both req bits high -> grant the requester not served last; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-014 Gk, req[k] low at an edge: if the other req is high, move directly to the other grant state with no IDLE gap; otherwise go to IDLE.
REQ-015 Gk, req[k] high: stay in Gk, with hold counter incrementing every cycle; the counter clears to 0 on every entry into G0 or G1.
REQ-016 Gk, req[k] high, other req high, and hold counter = MAX_HOLD-1 -> forced switch to the other grant state at that edge; the grant therefore lasts exactly MAX_HOLD cycles.
REQ-017 Gk, other req low: the hold counter saturates at MAX_HOLD-1 and no switch occurs, so the grant holds indefinitely.
REQ-018 A forced switch also applies when the other request arrives after saturation; the switch occurs at the first edge where the other req is seen high.
REQ-019 Last-served pointer updates to k on every entry into Gk.
REQ-020 gnt never has both bits high; s changes only on a state transition.
REQ-021 Hold counter width: ceil(log2(MAX_HOLD)) bits, unsigned, never wraps.

Reset
REQ-022 rst_n low -> immediately (asynchronously): state IDLE, gnt=00, s=0, valid=0, o=0, hold counter=0, last-served pointer=1.
REQ-023 Reset asserted mid-grant aborts the grant with no completion cycle; after release, arbitration restarts per REQ-012/013 at the first rising edge.

Structure
REQ-024 Shared header/package holds the state encodings (IDLE=2'b00, G0=2'b01, G1=2'b10) and the MAX_HOLD default.
REQ-025 The 2:1 data selection is one sub-module, mux2_sel (ports i[1:0], s, o), instantiated once; the FSM and hold counter reside in mux2_arbiter.

Verification
REQ-026 Reset release, req=01 at edge 1 -> gnt=01, s=0, valid=1 from cycle 2; with i=10, o=0.
REQ-027 IDLE, req=11 first tie -> G0 granted; drop req[0] -> G1 granted next cycle with no IDLE; o tracks i[1].
REQ-028 MAX_HOLD=8, req=11 held constant -> grants alternate G0/G1, exactly 8 cycles each, no gap cycles.
REQ-029 req=01 for 20 cycles -> G0 held all 20 cycles; req[1] raised at cycle 20 -> switch to G1 at the next edge (saturated counter).
REQ-030 rst_n pulsed low mid-G1 -> gnt=00, valid=0, o=0 within the same cycle, without waiting for a clock edge; after release, req=11 -> G0 granted (pointer reset to 1).
